// File: rtl/hazard_unit_pkg.sv
// Shared widths and the pipeline control-bit record used by the hazard unit.
package hazard_unit_pkg;

  localparam int unsigned REG_W = 5;
  localparam int unsigned CNT_W = 16;

  // Control bits that travel with an instruction down the pipeline
  typedef struct packed {
    logic             regwrite;
    logic             memread;
    logic             memwrite;
    logic [REG_W-1:0] rd;
  } ctrl_t;

endpackage

// File: rtl/hazard_unit_if.sv
// Hazard unit bus: ID-stage operand/control info in, stall controls out.
//   master : pipeline side (drives ID info and DMemReady_i, reads stall controls)
//   slave  : hazard unit
interface hazard_if
  import hazard_unit_pkg::*;
();

  logic [REG_W-1:0] IF_ID_Rs_i;
  logic [REG_W-1:0] IF_ID_Rt_i;
  logic             UsesRt_i;
  logic             Branch_i;
  logic [REG_W-1:0] ID_Rd_i;
  logic             ID_RegWrite_i;
  logic             ID_MemRead_i;
  logic             ID_MemWrite_i;
  logic             DMemReady_i;
  logic             IsHazzard_o;
  logic             PC_Write_o;
  logic             IF_ID_Write_o;
  logic             Freeze_o;
  logic [CNT_W-1:0] StallCount_o;

  modport master (
    output IF_ID_Rs_i, IF_ID_Rt_i, UsesRt_i, Branch_i, ID_Rd_i,
           ID_RegWrite_i, ID_MemRead_i, ID_MemWrite_i, DMemReady_i,
    input  IsHazzard_o, PC_Write_o, IF_ID_Write_o, Freeze_o, StallCount_o
  );

  modport slave (
    input  IF_ID_Rs_i, IF_ID_Rt_i, UsesRt_i, Branch_i, ID_Rd_i,
           ID_RegWrite_i, ID_MemRead_i, ID_MemWrite_i, DMemReady_i,
    output IsHazzard_o, PC_Write_o, IF_ID_Write_o, Freeze_o, StallCount_o
  );

endinterface

// File: rtl/hazard_unit_stall_counter.sv
// Saturating stall-cycle counter with enable and synchronous active-low clear.
//   clk_i   : clock
//   rst_i   : synchronous active-low clear
//   en_i    : count this edge
//   count_o : current count, sticks at all-ones
module stall_counter
  import hazard_unit_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_count <= '0;
    end else if (en_i && (r_count != {CNT_W{1'b1}})) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign count_o = r_count;

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: load-use and branch-operand bubbles, data-memory
// wait freeze, and a saturating stall counter.
//   clk_i : clock
//   rst_i : synchronous active-low reset
//   bus   : hazard_if.slave (ID info + DMemReady_i in, stall controls out)
module hazard_unit
  import hazard_unit_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  hazard_if.slave bus
);

  ctrl_t            r_ex;
  ctrl_t            r_mem;
  ctrl_t            w_id;
  logic             w_ex_rs;
  logic             w_ex_rt;
  logic             w_mem_rs;
  logic             w_mem_rt;
  logic             w_load_use;
  logic             w_branch_dep;
  logic             w_mem_wait;
  logic             w_hazard;
  logic             w_freeze;
  logic [CNT_W-1:0] w_count;

  assign w_id = '{regwrite: bus.ID_RegWrite_i,
                  memread:  bus.ID_MemRead_i,
                  memwrite: bus.ID_MemWrite_i,
                  rd:       bus.ID_Rd_i};

  // Non-zero destination matches against the ID source operands
  assign w_ex_rs  = (r_ex.rd  != '0) && (r_ex.rd  == bus.IF_ID_Rs_i);
  assign w_ex_rt  = (r_ex.rd  != '0) && (r_ex.rd  == bus.IF_ID_Rt_i);
  assign w_mem_rs = (r_mem.rd != '0) && (r_mem.rd == bus.IF_ID_Rs_i);
  assign w_mem_rt = (r_mem.rd != '0) && (r_mem.rd == bus.IF_ID_Rt_i);

  assign w_load_use   = r_ex.memread && (w_ex_rs || (bus.UsesRt_i && w_ex_rt));
  assign w_branch_dep = bus.Branch_i &&
                        ((r_ex.regwrite && (w_ex_rs || w_ex_rt)) ||
                         (r_mem.memread && (w_mem_rs || w_mem_rt)));
  assign w_mem_wait   = (r_mem.memread || r_mem.memwrite) && !bus.DMemReady_i;

  // Freeze wins over bubble; both forced inactive while reset is asserted
  assign w_freeze = rst_i && w_mem_wait;
  assign w_hazard = rst_i && (w_load_use || w_branch_dep) && !w_mem_wait;

  // Shadow pipeline copy; DMemReady_i only reaches it through the hold enable
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_ex  <= '0;
      r_mem <= '0;
    end else if (!w_freeze) begin
      r_mem <= r_ex;
      r_ex  <= w_hazard ? ctrl_t'('0) : w_id;
    end
  end

  stall_counter u_stall_counter (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .en_i    (w_hazard || w_freeze),
    .count_o (w_count)
  );

  assign bus.IsHazzard_o   = w_hazard;
  assign bus.Freeze_o      = w_freeze;
  assign bus.PC_Write_o    = !(w_hazard || w_freeze);
  assign bus.IF_ID_Write_o = !(w_hazard || w_freeze);
  assign bus.StallCount_o  = rst_i ? w_count : '0;

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed pipeline scenarios plus
// random traffic, all checked against an instruction-level model.
module tb_hazard_unit;
  import hazard_unit_pkg::*;

  logic clk;
  logic rst_i;

  hazard_if hif ();

  hazard_unit dut (
    .clk_i (clk),
    .rst_i (rst_i),
    .bus   (hif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Model: pipe[0] is the instruction in EX, pipe[1] the one in MEM
  ctrl_t pipe [2];
  int    m_cnt;
  logic  g_hz, g_fz;

  // Bench copies of the current inputs
  logic [4:0] s_rs, s_rt, s_rd;
  logic       s_ur, s_br, s_rw, s_mr, s_mw, s_rdy, s_rst;

  task automatic chk(input string name, input int act, input int exp);
    n_assert++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_eval(output logic e_hz, output logic e_fz);
    ctrl_t ex, mem;
    logic  lu, bd, mw;
    ex  = pipe[0];
    mem = pipe[1];
    lu = ex.memread && ex.rd != 0 &&
         (ex.rd == s_rs || (s_ur && ex.rd == s_rt));
    bd = s_br && ((ex.regwrite && ex.rd != 0 && (ex.rd == s_rs || ex.rd == s_rt)) ||
                  (mem.memread && mem.rd != 0 && (mem.rd == s_rs || mem.rd == s_rt)));
    mw = (mem.memread || mem.memwrite) && !s_rdy;
    if (!s_rst) begin
      e_hz = 1'b0;
      e_fz = 1'b0;
    end else begin
      e_fz = mw;
      e_hz = (lu || bd) && !mw;
    end
  endtask

  // Apply one cycle of inputs (at negedge) and check all outputs vs model
  task automatic cyc(input logic [4:0] rs, input logic [4:0] rt, input logic ur,
                     input logic br, input logic [4:0] rd, input logic rw,
                     input logic mr, input logic mw, input logic rdy, input logic rst);
    s_rs = rs; s_rt = rt; s_ur = ur; s_br = br; s_rd = rd;
    s_rw = rw; s_mr = mr; s_mw = mw; s_rdy = rdy; s_rst = rst;
    hif.IF_ID_Rs_i    = rs;
    hif.IF_ID_Rt_i    = rt;
    hif.UsesRt_i      = ur;
    hif.Branch_i      = br;
    hif.ID_Rd_i       = rd;
    hif.ID_RegWrite_i = rw;
    hif.ID_MemRead_i  = mr;
    hif.ID_MemWrite_i = mw;
    hif.DMemReady_i   = rdy;
    rst_i             = rst;
    #1;
    model_eval(g_hz, g_fz);
    chk("IsHazzard_o",   int'(hif.IsHazzard_o),   int'(g_hz));
    chk("Freeze_o",      int'(hif.Freeze_o),      int'(g_fz));
    chk("PC_Write_o",    int'(hif.PC_Write_o),    int'(!(g_hz || g_fz)));
    chk("IF_ID_Write_o", int'(hif.IF_ID_Write_o), int'(!(g_hz || g_fz)));
    chk("StallCount_o",  int'(hif.StallCount_o),  s_rst ? m_cnt : 0);
  endtask

  // Clock edge: advance the instruction-level model, return at next negedge
  task automatic adv();
    @(posedge clk);
    if (!s_rst) begin
      pipe[0] = '0;
      pipe[1] = '0;
      m_cnt   = 0;
    end else begin
      if ((g_hz || g_fz) && m_cnt < 65535) m_cnt++;
      if (!g_fz) begin
        pipe[1] = pipe[0];
        pipe[0] = g_hz ? ctrl_t'('0)
                       : '{regwrite: s_rw, memread: s_mr, memwrite: s_mw, rd: s_rd};
      end
    end
    @(negedge clk);
  endtask

  task automatic nop(input logic rdy);
    cyc(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, rdy, 1'b1);
    adv();
  endtask

  int base;

  initial begin
    pipe[0] = '0;
    pipe[1] = '0;
    m_cnt   = 0;
    @(negedge clk);

    // Reset: outputs forced to their idle values
    for (int i = 0; i < 2; i++) begin
      cyc(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("reset_hz",   int'(hif.IsHazzard_o), 0);
      chk("reset_pcw",  int'(hif.PC_Write_o), 1);
      chk("reset_cnt",  int'(hif.StallCount_o), 0);
      adv();
    end

    // Load-use: lw $2 then use of $2 -> one bubble
    cyc(5'd0, 5'd0, 1'b0, 1'b0, 5'd2, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1); adv();
    cyc(5'd2, 5'd5, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("lu_hz1",  int'(hif.IsHazzard_o), 1);
    chk("lu_pcw1", int'(hif.PC_Write_o), 0);
    adv();
    cyc(5'd2, 5'd5, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("lu_hz2",  int'(hif.IsHazzard_o), 0);
    chk("lu_pcw2", int'(hif.PC_Write_o), 1);
    chk("lu_cnt",  int'(hif.StallCount_o), 1);
    adv();
    nop(1'b1); nop(1'b1);

    // No false hazard: lw $0 / use $0, and lw $3 with Rt=3 unused
    cyc(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1); adv();
    cyc(5'd0, 5'd0, 1'b1, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("r0_hz", int'(hif.IsHazzard_o), 0);
    adv(); nop(1'b1); nop(1'b1);
    cyc(5'd0, 5'd0, 1'b0, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1); adv();
    cyc(5'd1, 5'd3, 1'b0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("nort_hz", int'(hif.IsHazzard_o), 0);
    adv(); nop(1'b1); nop(1'b1);

    // Branch after load: lw $4 ; beq $4,$5 -> two bubbles
    base = m_cnt;
    cyc(5'd0, 5'd0, 1'b0, 1'b0, 5'd4, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1); adv();
    for (int i = 0; i < 3; i++) begin
      cyc(5'd4, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      chk("brld_hz", int'(hif.IsHazzard_o), (i < 2) ? 1 : 0);
      if (i == 2) chk("brld_cnt", int'(hif.StallCount_o), base + 2);
      adv();
    end
    nop(1'b1); nop(1'b1);

    // Branch after ALU op: add $6 ; beq $6 -> one bubble
    base = m_cnt;
    cyc(5'd0, 5'd0, 1'b0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1); adv();
    for (int i = 0; i < 2; i++) begin
      cyc(5'd1, 5'd6, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      chk("bralu_hz", int'(hif.IsHazzard_o), (i < 1) ? 1 : 0);
      adv();
    end
    chk("bralu_cnt", m_cnt, base + 1);
    nop(1'b1); nop(1'b1);

    // Memory wait overlapping a load-use: 3 freeze cycles then 1 bubble
    base = m_cnt;
    cyc(5'd0, 5'd0, 1'b0, 1'b0, 5'd6, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1); adv();
    cyc(5'd0, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1); adv();
    for (int i = 0; i < 3; i++) begin
      cyc(5'd7, 5'd0, 1'b0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("mw_fz", int'(hif.Freeze_o), 1);
      chk("mw_hz", int'(hif.IsHazzard_o), 0);
      adv();
    end
    cyc(5'd7, 5'd0, 1'b0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("mw_bub_hz", int'(hif.IsHazzard_o), 1);
    chk("mw_bub_fz", int'(hif.Freeze_o), 0);
    adv();
    cyc(5'd7, 5'd0, 1'b0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("mw_done_hz", int'(hif.IsHazzard_o), 0);
    chk("mw_cnt", int'(hif.StallCount_o), base + 4);
    adv();
    nop(1'b1); nop(1'b1);

    // Reset during the second freeze cycle
    cyc(5'd0, 5'd0, 1'b0, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1); adv();
    nop(1'b1);
    cyc(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("rf_fz1", int'(hif.Freeze_o), 1);
    adv();
    cyc(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    adv();
    cyc(5'd8, 5'd8, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("rf_fz",  int'(hif.Freeze_o), 0);
    chk("rf_hz",  int'(hif.IsHazzard_o), 0);
    chk("rf_cnt", int'(hif.StallCount_o), 0);
    adv();

    // Random traffic: small register range to provoke matches
    for (int i = 0; i < 3000; i++) begin
      cyc(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 63) != 0));
      adv();
    end

    // Saturation: reset, then a long freeze behind a stalled load
    cyc(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0); adv();
    cyc(5'd0, 5'd0, 1'b0, 1'b0, 5'd1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1); adv();
    nop(1'b1);
    for (int i = 0; i < 65534; i++) nop(1'b0);
    cyc(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("sat_pre", int'(hif.StallCount_o), 16'hFFFE);
    adv();
    for (int i = 0; i < 3; i++) begin
      cyc(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("sat_cnt", int'(hif.StallCount_o), 16'hFFFF);
      adv();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
